// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared types and helpers for the data-memory arbiter.
//   - FN3_* load/store size codes as seen on the memory fn3 pins
//   - state_e: arbiter FSM states
//   - req_t: a latched memory request (address, store data, direction, size, winner id)
//   - req_error(): window and alignment check applied when a request is accepted
package dmem_arb_pkg;

  localparam logic [2:0] FN3_LB  = 3'b000;
  localparam logic [2:0] FN3_LH  = 3'b001;
  localparam logic [2:0] FN3_LW  = 3'b010;
  localparam logic [2:0] FN3_LBU = 3'b100;
  localparam logic [2:0] FN3_LHU = 3'b101;
  localparam logic [2:0] FN3_SB  = 3'b000;
  localparam logic [2:0] FN3_SH  = 3'b001;
  localparam logic [2:0] FN3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [2:0]  fn3;
    logic        id;
  } req_t;

  // The window limit is computed one bit wider so a window ending at the top
  // of the address space cannot wrap. Stores have no unsigned variants, so
  // fn3 codes with bit 2 set are unknown for stores.
  function automatic logic req_error(input req_t r, input logic [31:0] base,
                                     input logic [31:0] span);
    logic [32:0] limit;
    logic        bad_range;
    logic        bad_align;
    logic        unknown;
    limit     = {1'b0, base} + {1'b0, span};
    bad_range = ({1'b0, r.addr} < {1'b0, base}) || ({1'b0, r.addr} >= limit);
    bad_align = 1'b0;
    unknown   = 1'b0;
    case (r.fn3)
      3'b000:         bad_align = 1'b0;
      3'b001:         bad_align = r.addr[0];
      3'b010:         bad_align = |r.addr[1:0];
      3'b100:         unknown   = r.we;
      3'b101: begin
        unknown   = r.we;
        bad_align = r.addr[0];
      end
      default:        unknown   = 1'b1;
    endcase
    return bad_range | bad_align | unknown;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port of the data-memory arbiter.
//   req_valid/req_ready : request handshake (accepted when both high at a clock edge)
//   addr/wdata/we/fn3   : request payload
//   rsp_valid           : one-cycle response pulse
//   rdata/err           : response payload, meaningful only with rsp_valid
// modport master = requester side, modport slave = arbiter side.
interface dmem_arbiter_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [2:0]  fn3;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req_valid, addr, wdata, we, fn3,
                  input  req_ready, rsp_valid, rdata, err);
  modport slave  (input  req_valid, addr, wdata, we, fn3,
                  output req_ready, rsp_valid, rdata, err);
endinterface

// File: rtl/dmem_arbiter_rr.sv
// dmem_rr_arbiter: two-way grant for the data-memory arbiter.
//   clk, rst       : clock, asynchronous active-high reset
//   en             : arbiter is able to accept a request this cycle
//   valid0/valid1  : requesters asking for the memory
//   grant0/grant1  : combinational one-hot grant (doubles as req_ready)
// With both requesting, FIXED_PRIO!=0 always picks port 0; otherwise the
// port that did not win last time is picked.
module dmem_rr_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

  logic last_grant;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (en) begin
      if (valid0 && valid1) begin
        if ((FIXED_PRIO != 0) || last_grant) grant0 = 1'b1;
        else                                 grant1 = 1'b1;
      end else begin
        grant0 = valid0;
        grant1 = valid1;
      end
    end
  end

  // Resetting to 1 makes port 0 the first winner under contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   last_grant <= 1'b1;
    else if (grant0 || grant1) last_grant <= grant1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU (m0) and a
// loader/debug DMA (m1).
//   clk, rst            : clock, asynchronous active-high reset
//   m0, m1              : requester ports (dmem_arbiter_if slave side)
//   mem_addr/mem_wdata  : to memory addr_in/data_in
//   mem_we/mem_fn3      : to memory wr_en/fn3
//   mem_rdata           : from memory data_out (already sized/extended)
// An accepted request is latched, driven on the memory pins for one ACCESS
// cycle, and answered with a one-cycle response in RESP. Bad requests get
// the same timing but never write memory and return rdata 0 with err set.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = 32'h8000_2000,
  parameter logic [31:0] ADDR_SPAN  = 32'h0000_4000,
  parameter int          FIXED_PRIO = 0
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  m0,
  dmem_arbiter_if.slave  m1,
  output logic [31:0]    mem_addr,
  output logic [31:0]    mem_wdata,
  output logic           mem_we,
  output logic [2:0]     mem_fn3,
  input  logic [31:0]    mem_rdata
);

  state_e      state;
  state_e      state_next;
  req_t        cur;
  req_t        incoming;
  logic        err_q;
  logic [31:0] rdata_q;
  logic        accept_en;
  logic        grant0;
  logic        grant1;
  logic        accept;

  assign accept_en = (state == IDLE) || (state == RESP);
  assign accept    = grant0 | grant1;

  dmem_rr_arbiter #(.FIXED_PRIO(FIXED_PRIO)) u_rr (
    .clk    (clk),
    .rst    (rst),
    .en     (accept_en),
    .valid0 (m0.req_valid),
    .valid1 (m1.req_valid),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign m0.req_ready = grant0;
  assign m1.req_ready = grant1;

  always_comb begin
    incoming = '0;
    if (grant1) begin
      incoming.addr  = m1.addr;
      incoming.wdata = m1.wdata;
      incoming.we    = m1.we;
      incoming.fn3   = m1.fn3;
      incoming.id    = 1'b1;
    end else begin
      incoming.addr  = m0.addr;
      incoming.wdata = m0.wdata;
      incoming.we    = m0.we;
      incoming.fn3   = m0.fn3;
      incoming.id    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = accept ? ACCESS : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The latched request only changes on an accept edge, which always leads
  // into ACCESS, so outside ACCESS the memory pins keep their last values.
  // Read data is captured at the end of ACCESS; stores and errors return 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur     <= '{addr: ADDR_BASE, wdata: 32'h0, we: 1'b0, fn3: FN3_LW, id: 1'b0};
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      if (accept) begin
        cur   <= incoming;
        err_q <= req_error(incoming, ADDR_BASE, ADDR_SPAN);
      end
      if (state == ACCESS) rdata_q <= (cur.we || err_q) ? 32'h0 : mem_rdata;
    end
  end

  assign mem_addr  = cur.addr;
  assign mem_wdata = cur.wdata;
  assign mem_fn3   = cur.fn3;
  assign mem_we    = (state == ACCESS) & cur.we & ~err_q;

  assign m0.rsp_valid = (state == RESP) & ~cur.id;
  assign m1.rsp_valid = (state == RESP) &  cur.id;
  assign m0.rdata     = m0.rsp_valid ? rdata_q : 32'h0;
  assign m1.rdata     = m1.rsp_valid ? rdata_q : 32'h0;
  assign m0.err       = m0.rsp_valid & err_q;
  assign m1.err       = m1.rsp_valid & err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter.
// Stimulus pushes the hand-computed response of every accepted request into
// a queue; a monitor pops and compares whenever a port shows rsp_valid.
// A second instance with FIXED_PRIO=1 is used for the priority check only.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_2000;
  localparam logic [31:0] SPAN = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [2:0]  mem_fn3;
  logic [31:0] fp_mem_addr, fp_mem_wdata, fp_mem_rdata;
  logic        fp_mem_we;
  logic [2:0]  fp_mem_fn3;

  dmem_arbiter_if m0_if();
  dmem_arbiter_if m1_if();
  dmem_arbiter_if fp0_if();
  dmem_arbiter_if fp1_if();

  dmem_arbiter #(.ADDR_BASE(BASE), .ADDR_SPAN(SPAN), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_fn3(mem_fn3), .mem_rdata(mem_rdata));

  dmem_arbiter #(.ADDR_BASE(BASE), .ADDR_SPAN(SPAN), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst), .m0(fp0_if), .m1(fp1_if),
    .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_we(fp_mem_we),
    .mem_fn3(fp_mem_fn3), .mem_rdata(fp_mem_rdata));

  assign fp_mem_rdata = 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  // Byte-addressed model of the data memory: reads and writes on the falling
  // edge inside the access cycle, sized by fn3 like the real memory.
  logic [7:0] mem_bytes [0:16383];

  function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [2:0] f);
    logic [31:0] off;
    logic [31:0] w;
    logic [13:0] idx;
    off = a - BASE;
    if (a < BASE || off > 32'h3FFC) return 32'h0;
    idx = off[13:0];
    w = {mem_bytes[idx + 14'd3], mem_bytes[idx + 14'd2], mem_bytes[idx + 14'd1], mem_bytes[idx]};
    case (f)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b010:  return w;
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    logic [31:0] off;
    logic [13:0] idx;
    off = a - BASE;
    if (a < BASE || off > 32'h3FFC) return;
    idx = off[13:0];
    mem_bytes[idx] = d[7:0];
    if (f != 3'b000) mem_bytes[idx + 14'd1] = d[15:8];
    if (f == 3'b010) begin
      mem_bytes[idx + 14'd2] = d[23:16];
      mem_bytes[idx + 14'd3] = d[31:24];
    end
  endtask

  int we_pulses = 0;
  always @(negedge clk) begin
    mem_rdata <= mem_read(mem_addr, mem_fn3);
    if (mem_we) begin
      mem_write(mem_addr, mem_wdata, mem_fn3);
      we_pulses++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_rsp(input int port, input logic [31:0] rd, input logic er);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_rsp port=%0d actual=rsp_valid expected=none", port);
    end else begin
      e = sb.pop_front();
      checkOutput("rsp_port", port, e.port);
      checkOutput("rsp_rdata", rd, e.rdata);
      checkOutput("rsp_err", 32'(er), 32'(e.err));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (m0_if.rsp_valid) check_rsp(0, m0_if.rdata, m0_if.err);
      if (m1_if.rsp_valid) check_rsp(1, m1_if.rdata, m1_if.err);
    end
  end

  task automatic set_req(input int port, input logic valid, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic we, input logic [2:0] fn3);
    if (port == 0) begin
      m0_if.req_valid = valid; m0_if.addr = addr; m0_if.wdata = wdata;
      m0_if.we = we; m0_if.fn3 = fn3;
    end else begin
      m1_if.req_valid = valid; m1_if.addr = addr; m1_if.wdata = wdata;
      m1_if.we = we; m1_if.fn3 = fn3;
    end
  endtask

  // Drives one request, waits (bounded) for it to be accepted, pushes its
  // expected response and returns one step after the accept edge.
  task automatic applyStimulus(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic we, input logic [2:0] fn3,
                               input logic [31:0] exp_rdata, input logic exp_err);
    logic got;
    logic rdy;
    got = 1'b0;
    set_req(port, 1'b1, addr, wdata, we, fn3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rdy = (port == 0) ? m0_if.req_ready : m1_if.req_ready;
      if (rdy) begin
        sb.push_back('{port: port, rdata: exp_rdata, err: exp_err});
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout port=%0d addr=%h actual=no_ready expected=ready", port, addr);
    end
    @(posedge clk);
    #1;
    set_req(port, 1'b0, 32'h0, 32'h0, 1'b0, FN3_LW);
  endtask

  logic [31:0] rr_addr0 [2] = '{32'h8000_2100, 32'h8000_2104};
  logic [31:0] rr_data0 [2] = '{32'hA000_0001, 32'hA000_0002};
  logic [31:0] rr_addr1 [2] = '{32'h8000_2200, 32'h8000_2204};
  logic [31:0] rr_data1 [2] = '{32'hB000_0001, 32'hB000_0002};
  logic [31:0] b2b_addr [3] = '{32'h8000_2100, 32'h8000_2104, 32'h8000_2200};
  logic [31:0] b2b_data [3] = '{32'hA000_0001, 32'hA000_0002, 32'hB000_0001};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, m0_n, m1_n, prev, we_start, fp_g0, fp_g1;
    int order [4];
    logic g0, g1, got;

    for (int i = 0; i < 16384; i++) mem_bytes[i] = 8'h00;
    mem_write(32'h8000_2004, 32'h1122_3344, FN3_SW);
    mem_write(32'h8000_2100, 32'hA000_0001, FN3_SW);
    mem_write(32'h8000_2104, 32'hA000_0002, FN3_SW);
    mem_write(32'h8000_2200, 32'hB000_0001, FN3_SW);
    mem_write(32'h8000_2204, 32'hB000_0002, FN3_SW);
    mem_write(32'h8000_5FFC, 32'h5A5A_1234, FN3_SW);

    set_req(0, 1'b0, 32'h0, 32'h0, 1'b0, FN3_LW);
    set_req(1, 1'b0, 32'h0, 32'h0, 1'b0, FN3_LW);
    fp0_if.req_valid = 1'b0; fp0_if.addr = BASE; fp0_if.wdata = 32'h0; fp0_if.we = 1'b0; fp0_if.fn3 = FN3_LW;
    fp1_if.req_valid = 1'b0; fp1_if.addr = BASE; fp1_if.wdata = 32'h0; fp1_if.we = 1'b0; fp1_if.fn3 = FN3_LW;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_mem_addr", mem_addr, BASE);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rst_mem_fn3", 32'(mem_fn3), 32'(FN3_LW));
    checkOutput("rst_m0_rsp", 32'(m0_if.rsp_valid), 32'h0);
    checkOutput("rst_m1_rsp", 32'(m1_if.rsp_valid), 32'h0);
    checkOutput("rst_m0_rdata", m0_if.rdata, 32'h0);
    checkOutput("rst_m1_err", 32'(m1_if.err), 32'h0);
    rst = 1'b0;

    // Single load with latency T+2
    applyStimulus(0, 32'h8000_2004, 32'h0, 1'b0, FN3_LW, 32'h1122_3344, 1'b0);
    checkOutput("lat_access_no_rsp", 32'(m0_if.rsp_valid), 32'h0);
    checkOutput("lat_access_addr", mem_addr, 32'h8000_2004);
    checkOutput("lat_access_we", 32'(mem_we), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("lat_rsp_valid", 32'(m0_if.rsp_valid), 32'h1);
    checkOutput("lat_rsp_rdata", m0_if.rdata, 32'h1122_3344);

    // Error cases: none may pulse mem_we
    we_start = we_pulses;
    applyStimulus(0, 32'h8000_2002, 32'hFFFF_FFFF, 1'b1, FN3_SW, 32'h0, 1'b1);
    applyStimulus(0, 32'h8000_6000, 32'h0, 1'b0, FN3_LW, 32'h0, 1'b1);
    applyStimulus(0, 32'h8000_2003, 32'h0, 1'b0, FN3_LH, 32'h0, 1'b1);
    applyStimulus(0, 32'h8000_2004, 32'h0, 1'b0, 3'b011, 32'h0, 1'b1);
    applyStimulus(0, 32'h8000_1FFC, 32'h0, 1'b0, FN3_LW, 32'h0, 1'b1);
    applyStimulus(0, 32'h8000_2004, 32'h1234_5678, 1'b1, FN3_LBU, 32'h0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("err_no_mem_we", we_pulses - we_start, 0);
    applyStimulus(0, 32'h8000_5FFC, 32'h0, 1'b0, FN3_LW, 32'h5A5A_1234, 1'b0);
    applyStimulus(0, 32'h8000_2004, 32'h0, 1'b0, FN3_LW, 32'h1122_3344, 1'b0);

    // Store byte then read it back on m1
    applyStimulus(1, 32'h8000_2001, 32'h0000_00A5, 1'b1, FN3_SB, 32'h0, 1'b0);
    checkOutput("sb_mem_we", 32'(mem_we), 32'h1);
    applyStimulus(1, 32'h8000_2001, 32'h0, 1'b0, FN3_LBU, 32'h0000_00A5, 1'b0);
    applyStimulus(1, 32'h8000_2001, 32'h0, 1'b0, FN3_LB, 32'hFFFF_FFA5, 1'b0);
    applyStimulus(1, 32'h8000_2000, 32'h0, 1'b0, FN3_LW, 32'h0000_A500, 1'b0);

    // Round-robin contention: m0, m1, m0, m1
    for (int k = 0; k < 4; k++) order[k] = -1;
    n = 0; m0_n = 0; m1_n = 0;
    set_req(0, 1'b1, rr_addr0[0], 32'h0, 1'b0, FN3_LW);
    set_req(1, 1'b1, rr_addr1[0], 32'h0, 1'b0, FN3_LW);
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      g0 = m0_if.req_ready;
      g1 = m1_if.req_ready;
      if (g0 || g1) begin
        if (g0) begin
          sb.push_back('{port: 0, rdata: rr_data0[m0_n], err: 1'b0});
          order[n] = 0;
        end else begin
          sb.push_back('{port: 1, rdata: rr_data1[m1_n], err: 1'b0});
          order[n] = 1;
        end
        n++;
        @(posedge clk);
        #1;
        if (g0) begin
          m0_n++;
          if (m0_n < 2) set_req(0, 1'b1, rr_addr0[m0_n], 32'h0, 1'b0, FN3_LW);
          else          set_req(0, 1'b0, 32'h0, 32'h0, 1'b0, FN3_LW);
        end else begin
          m1_n++;
          if (m1_n < 2) set_req(1, 1'b1, rr_addr1[m1_n], 32'h0, 1'b0, FN3_LW);
          else          set_req(1, 1'b0, 32'h0, 32'h0, 1'b0, FN3_LW);
        end
      end
    end
    set_req(0, 1'b0, 32'h0, 32'h0, 1'b0, FN3_LW);
    set_req(1, 1'b0, 32'h0, 32'h0, 1'b0, FN3_LW);
    for (int k = 0; k < 4; k++) checkOutput("rr_order", order[k], k % 2);

    // Back-to-back on m0: accept every 2 cycles, coincident with the response
    n = 0; prev = 0;
    set_req(0, 1'b1, b2b_addr[0], 32'h0, 1'b0, FN3_LW);
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (m0_if.req_ready) begin
        sb.push_back('{port: 0, rdata: b2b_data[n], err: 1'b0});
        if (n > 0) begin
          checkOutput("b2b_spacing", cyc - prev, 2);
          checkOutput("b2b_rsp_coincident", 32'(m0_if.rsp_valid), 32'h1);
        end
        prev = cyc;
        n++;
        @(posedge clk);
        #1;
        if (n < 3) set_req(0, 1'b1, b2b_addr[n], 32'h0, 1'b0, FN3_LW);
        else       set_req(0, 1'b0, 32'h0, 32'h0, 1'b0, FN3_LW);
      end
    end
    checkOutput("b2b_accepts", n, 3);
    repeat (3) @(posedge clk);
    #1;

    // Reset during ACCESS aborts a store on m0
    got = 1'b0;
    set_req(0, 1'b1, 32'h8000_2010, 32'hCAFE_F00D, 1'b1, FN3_SW);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m0_if.req_ready) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("abort_accept", 32'(got), 32'h1);
    @(posedge clk);
    #1;
    checkOutput("abort_we_in_access", 32'(mem_we), 32'h1);
    rst = 1'b1;
    set_req(0, 1'b0, 32'h0, 32'h0, 1'b0, FN3_LW);
    #1;
    checkOutput("abort_mem_we", 32'(mem_we), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("abort_no_rsp", 32'(m0_if.rsp_valid), 32'h0);
    end
    set_req(0, 1'b1, 32'h8000_2010, 32'h0, 1'b0, FN3_LW);
    set_req(1, 1'b1, 32'h8000_2004, 32'h0, 1'b0, FN3_LW);
    @(negedge clk);
    checkOutput("post_rst_grant_m0", 32'(m0_if.req_ready), 32'h1);
    checkOutput("post_rst_m1_waits", 32'(m1_if.req_ready), 32'h0);
    if (m0_if.req_ready) sb.push_back('{port: 0, rdata: 32'h0, err: 1'b0});
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 32'h0, 32'h0, 1'b0, FN3_LW);
    applyStimulus(1, 32'h8000_2004, 32'h0, 1'b0, FN3_LW, 32'h1122_3344, 1'b0);

    // Fixed priority instance: m0 held valid always wins
    fp_g0 = 0; fp_g1 = 0;
    fp0_if.req_valid = 1'b1;
    fp1_if.req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fp0_if.req_ready) fp_g0++;
      if (fp1_if.req_ready) fp_g1++;
    end
    @(posedge clk);
    #1;
    fp0_if.req_valid = 1'b0;
    fp1_if.req_valid = 1'b0;
    checkOutput("fp_m0_grants", fp_g0, 5);
    checkOutput("fp_m1_grants", fp_g1, 0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    checkOutput("sb_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
